// File: rtl/alu_packet_engine.sv
// alu_packet_engine: device-side responder for the host packet protocol.
// Header: opcode, reserved byte, 16-bit little-endian total length.
// The payload holds big-endian 32-bit operands.
// Echo returns the payload unchanged; add and multiply return a 32-bit result, MSB first.
// Build option: define ALU_PACKET_MUL_EN to support OP_MUL (0xA1) with a 32x32 multiplier.
// Without it, 0xA1 is treated as an unsupported opcode.
module alu_packet_engine (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [7:0] rx_data_i,
   input  logic       rx_valid_i,
   output logic       rx_ready_o,
   output logic [7:0] tx_data_o,
   output logic       tx_valid_o,
   input  logic       tx_ready_i,
   output logic       busy_o,
   output logic       bad_op_o
);

   typedef enum logic [2:0] {
      ST_OPCODE, ST_RSVD, ST_LEN_LO, ST_LEN_HI, ST_PAYLOAD, ST_RESP
   } state_t;

   typedef enum logic [1:0] {K_ADD, K_MUL, K_ECHO, K_DROP} kind_t;

   // Map a received opcode onto the operation the payload stage performs.
   function automatic kind_t decode_op(input logic [7:0] op);
      kind_t k;
      case (op)
         8'hEC:   k = K_ECHO;
         8'hA0:   k = K_ADD;
`ifdef ALU_PACKET_MUL_EN
         8'hA1:   k = K_MUL;
`else
         8'hA1:   k = K_DROP;
`endif
         default: k = K_DROP;
      endcase
      return k;
   endfunction

   // Select the response byte for index idx, MSB first.
   function automatic logic [7:0] resp_byte(input logic [31:0] acc, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = acc[31:24];
         2'd1:    b = acc[23:16];
         2'd2:    b = acc[15:8];
         default: b = acc[7:0];
      endcase
      return b;
   endfunction

   state_t      state_r, state_nxt_s;
   kind_t       kind_r, kind_nxt_s;
   logic [7:0]  len_lo_r, len_lo_nxt_s;
   logic [15:0] cnt_r, cnt_nxt_s;
   logic [23:0] word_r, word_nxt_s;
   logic [1:0]  byte_idx_r, byte_idx_nxt_s;
   logic [31:0] acc_r, acc_nxt_s;
   logic [2:0]  resp_idx_r, resp_idx_nxt_s;
   logic [7:0]  tx_data_r, tx_data_nxt_s;
   logic        tx_valid_r, tx_valid_nxt_s;
   logic        rx_ready_r, rx_ready_nxt_s;
   logic        busy_r, bad_op_r, bad_op_nxt_s;

   logic        rx_hs_s, tx_hs_s;
   logic [15:0] len_s, pay_s;
   logic [31:0] word_s;

   assign rx_hs_s = rx_valid_i && rx_ready_r;
   assign tx_hs_s = tx_valid_r && tx_ready_i;
   assign len_s   = {rx_data_i, len_lo_r};
   assign pay_s   = (len_s > 16'd4) ? (len_s - 16'd4) : 16'd0;
   assign word_s  = {word_r, rx_data_i};

   // Next-state, datapath and output decisions; every next value defaults to hold.
   always_comb begin
      state_nxt_s    = state_r;
      kind_nxt_s     = kind_r;
      len_lo_nxt_s   = len_lo_r;
      cnt_nxt_s      = cnt_r;
      word_nxt_s     = word_r;
      byte_idx_nxt_s = byte_idx_r;
      acc_nxt_s      = acc_r;
      resp_idx_nxt_s = resp_idx_r;
      tx_data_nxt_s  = tx_data_r;
      bad_op_nxt_s   = 1'b0;
      rx_ready_nxt_s = 1'b1;
      // A completed tx handshake frees the output slot.
      if (tx_hs_s) begin
         tx_valid_nxt_s = 1'b0;
      end else begin
         tx_valid_nxt_s = tx_valid_r;
      end

      case (state_r)
         ST_OPCODE: begin
            if (rx_hs_s) begin
               kind_nxt_s   = decode_op(rx_data_i);
               bad_op_nxt_s = (decode_op(rx_data_i) == K_DROP);
               state_nxt_s  = ST_RSVD;
            end else begin
               state_nxt_s  = ST_OPCODE;
            end
         end
         ST_RSVD: begin
            if (rx_hs_s) begin
               state_nxt_s = ST_LEN_LO;
            end else begin
               state_nxt_s = ST_RSVD;
            end
         end
         ST_LEN_LO: begin
            if (rx_hs_s) begin
               len_lo_nxt_s = rx_data_i;
               state_nxt_s  = ST_LEN_HI;
            end else begin
               state_nxt_s  = ST_LEN_LO;
            end
         end
         ST_LEN_HI: begin
            if (rx_hs_s) begin
               cnt_nxt_s      = pay_s;
               acc_nxt_s      = (kind_r == K_MUL) ? 32'd1 : 32'd0;
               byte_idx_nxt_s = 2'd0;
               resp_idx_nxt_s = 3'd0;
               if (pay_s != 16'd0) begin
                  state_nxt_s = ST_PAYLOAD;
               end else if ((kind_r == K_ADD) || (kind_r == K_MUL)) begin
                  state_nxt_s = ST_RESP;
               end else begin
                  state_nxt_s = ST_OPCODE;
               end
            end else begin
               state_nxt_s = ST_LEN_HI;
            end
         end
         ST_PAYLOAD: begin
            if (rx_hs_s) begin
               cnt_nxt_s = cnt_r - 16'd1;
               case (kind_r)
                  K_ECHO: begin
                     tx_data_nxt_s  = rx_data_i;
                     tx_valid_nxt_s = 1'b1;
                  end
                  K_ADD: begin
                     word_nxt_s     = word_s[23:0];
                     byte_idx_nxt_s = byte_idx_r + 2'd1;
                     if (byte_idx_r == 2'd3) begin
                        acc_nxt_s = acc_r + word_s;
                     end else begin
                        acc_nxt_s = acc_r;
                     end
                  end
                  K_MUL: begin
                     word_nxt_s     = word_s[23:0];
                     byte_idx_nxt_s = byte_idx_r + 2'd1;
`ifdef ALU_PACKET_MUL_EN
                     if (byte_idx_r == 2'd3) begin
                        acc_nxt_s = acc_r * word_s;
                     end else begin
                        acc_nxt_s = acc_r;
                     end
`else
                     acc_nxt_s = acc_r;
`endif
                  end
                  default: begin
                     acc_nxt_s = acc_r;
                  end
               endcase
               if (cnt_r == 16'd1) begin
                  if ((kind_r == K_ADD) || (kind_r == K_MUL)) begin
                     state_nxt_s = ST_RESP;
                  end else begin
                     state_nxt_s = ST_OPCODE;
                  end
               end else begin
                  state_nxt_s = ST_PAYLOAD;
               end
            end else begin
               state_nxt_s = ST_PAYLOAD;
            end
         end
         ST_RESP: begin
            if ((resp_idx_r == 3'd4) && tx_hs_s) begin
               state_nxt_s = ST_OPCODE;
            end else begin
               state_nxt_s = ST_RESP;
            end
         end
         default: begin
            state_nxt_s = ST_OPCODE;
         end
      endcase

      // Response bytes are loaded whenever the tx slot is free, including on entry to RESP.
      if ((state_nxt_s == ST_RESP) && !tx_valid_nxt_s && (resp_idx_nxt_s != 3'd4)) begin
         tx_data_nxt_s  = resp_byte(acc_nxt_s, resp_idx_nxt_s[1:0]);
         tx_valid_nxt_s = 1'b1;
         resp_idx_nxt_s = resp_idx_nxt_s + 3'd1;
      end else begin
         resp_idx_nxt_s = resp_idx_nxt_s;
      end

      // rx_ready is registered, so it is derived from the upcoming state.
      case (state_nxt_s)
         ST_PAYLOAD: rx_ready_nxt_s = (kind_nxt_s == K_ECHO) ? !tx_valid_nxt_s : 1'b1;
         ST_RESP:    rx_ready_nxt_s = 1'b0;
         default:    rx_ready_nxt_s = 1'b1;
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_r    <= ST_OPCODE;
         kind_r     <= K_DROP;
         len_lo_r   <= 8'd0;
         cnt_r      <= 16'd0;
         word_r     <= 24'd0;
         byte_idx_r <= 2'd0;
         acc_r      <= 32'd0;
         resp_idx_r <= 3'd0;
         tx_data_r  <= 8'd0;
         tx_valid_r <= 1'b0;
         rx_ready_r <= 1'b0;
         busy_r     <= 1'b0;
         bad_op_r   <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         kind_r     <= kind_nxt_s;
         len_lo_r   <= len_lo_nxt_s;
         cnt_r      <= cnt_nxt_s;
         word_r     <= word_nxt_s;
         byte_idx_r <= byte_idx_nxt_s;
         acc_r      <= acc_nxt_s;
         resp_idx_r <= resp_idx_nxt_s;
         tx_data_r  <= tx_data_nxt_s;
         tx_valid_r <= tx_valid_nxt_s;
         rx_ready_r <= rx_ready_nxt_s;
         busy_r     <= (state_nxt_s != ST_OPCODE);
         bad_op_r   <= bad_op_nxt_s;
      end
   end

   assign rx_ready_o = rx_ready_r;
   assign tx_data_o  = tx_data_r;
   assign tx_valid_o = tx_valid_r;
   assign busy_o     = busy_r;
   assign bad_op_o   = bad_op_r;

endmodule
